// File: rtl/m_cp0.sv
// Coprocessor-0 for the M stage: raises exception/interrupt requests, captures
// the victim state, and exposes SR/Cause/EPC/PRId through mfc0/mtc0.
module m_cp0 #(
  parameter logic [31:0] PRID_VAL  = 32'h0000_4180,
  parameter logic [5:0]  SR_IM_RST = 6'b000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  output logic [31:0] CP0Out,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] EPCOut,
  output logic        Req
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  im_reg;
  logic        exl_reg;
  logic        ie_reg;
  logic        bd_reg;
  logic [5:0]  ip_reg;
  logic [4:0]  exc_code_reg;
  logic [31:0] epc_reg;

  logic [5:0]  int_pend;
  logic        int_req;
  logic        exc_req;
  logic        wr_sr;
  logic        wr_epc;
  logic [31:0] epc_wr_val;
  logic [31:0] epc_entry;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_int_pend
      assign int_pend[gi] = HWInt[gi] & im_reg[gi];
    end
  endgenerate

  // EXL masks both sources, so nothing nests while a handler is running.
  assign int_req = (|int_pend) & ie_reg & ~exl_reg;
  assign exc_req = (ExcCodeIn != 5'd0) & ~exl_reg;
  assign Req     = int_req | exc_req;

  assign wr_sr      = en & ~Req & (CP0Add == ADDR_SR);
  assign wr_epc     = en & ~Req & (CP0Add == ADDR_EPC);
  assign epc_wr_val = CP0In & 32'hFFFF_FFFC;
  assign epc_entry  = (BDIn ? (VPC - 32'd4) : VPC) & 32'hFFFF_FFFC;

  // Forward an in-flight EPC write so a following eret needs no stall.
  assign EPCOut = wr_epc ? epc_wr_val : epc_reg;

  always_comb begin
    CP0Out = 32'd0;
    case (CP0Add)
      ADDR_SR:    CP0Out = {16'd0, im_reg, 8'd0, exl_reg, ie_reg};
      ADDR_CAUSE: CP0Out = {bd_reg, 15'd0, ip_reg, 3'd0, exc_code_reg, 2'd0};
      ADDR_EPC:   CP0Out = epc_reg;
      ADDR_PRID:  CP0Out = PRID_VAL;
      default:    CP0Out = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_reg       <= SR_IM_RST;
      exl_reg      <= 1'b0;
      ie_reg       <= 1'b0;
      bd_reg       <= 1'b0;
      ip_reg       <= 6'd0;
      exc_code_reg <= 5'd0;
      epc_reg      <= 32'd0;
    end else begin
      ip_reg <= HWInt;
      if (Req) begin
        exl_reg      <= 1'b1;
        exc_code_reg <= int_req ? 5'd0 : ExcCodeIn;
        bd_reg       <= BDIn;
        epc_reg      <= epc_entry;
      end else begin
        // An eret in the same cycle as an SR write still clears EXL.
        if (wr_sr) begin
          im_reg  <= CP0In[15:10];
          ie_reg  <= CP0In[0];
          exl_reg <= CP0In[1] & ~EXLClr;
        end else if (EXLClr) begin
          exl_reg <= 1'b0;
        end
        if (wr_epc) begin
          epc_reg <= epc_wr_val;
        end
      end
    end
  end

endmodule
